uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one CoreUARTapb transmitter between up to four byte producers. It sits between the requesters and the UART core's host write port. It converts each accepted request byte into a single-cycle CSN/WEN write strobe, then paces the next write on the core's TXRDY. An optional packet lock keeps the grant on one requester until that requester marks its last byte, so multi-byte messages are not interleaved on the serial line.

---
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester handshake and UART host write port bundle
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 txrdy;
  logic                 uart_csn;
  logic                 uart_wen;
  logic [7:0]           uart_data;
  logic [1:0]           grant;
  logic                 locked;
  logic                 busy;

  modport slave (
    input  req_valid, req_data, req_last, txrdy,
    output req_ready, uart_csn, uart_wen, uart_data, grant, locked, busy
  );

  modport master (
    output req_valid, req_data, req_last, txrdy,
    input  req_ready, uart_csn, uart_wen, uart_data, grant, locked, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter
// Turns each accepted byte into a one-cycle CSN/WEN strobe and paces on TXRDY.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter bit LOCK_EN      = 1'b1,
  parameter int LOCK_TIMEOUT = 0
) (
  input logic              clk,
  input logic              reset_n,
  uart_tx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_SETTLE, S_WAIT} state_e;

  state_e      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  lock_idx_q, lock_idx_d;
  logic        locked_q, locked_d;
  logic        csn_q, csn_d;
  logic        wen_q, wen_d;
  logic        busy_q, busy_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] tcnt_q, tcnt_d;

  logic               win_found;
  logic [1:0]         win_idx;
  logic [1:0]         cand;
  logic [7:0]         win_data;
  logic               win_last;
  logic [NUM_REQ-1:0] ready;
  logic               accept;

  // Descending scan so the last hit is the nearest requester after ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    if (locked_q) begin
      win_found = bus.req_valid[lock_idx_q];
      win_idx   = lock_idx_q;
    end else begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        cand = 2'((int'(ptr_q) + k) % NUM_REQ);
        if (bus.req_valid[cand]) begin
          win_found = 1'b1;
          win_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    win_data = '0;
    win_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == 2'(i)) begin
        win_data = bus.req_data[i*8 +: 8];
        win_last = bus.req_last[i];
      end
    end
  end

  always_comb begin
    ready = '0;
    if (reset_n && state_q == S_IDLE && bus.txrdy && win_found) begin
      ready[win_idx] = 1'b1;
    end
  end

  assign accept = |(ready & bus.req_valid);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    lock_idx_d = lock_idx_q;
    locked_d   = locked_q;
    data_d     = data_q;
    tcnt_d     = tcnt_q;
    csn_d      = 1'b1;
    wen_d      = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_STROBE;
          csn_d   = 1'b0;
          wen_d   = 1'b0;
          data_d  = win_data;
          ptr_d   = win_idx;
          grant_d = win_idx;
          tcnt_d  = '0;
          if (LOCK_EN) begin
            locked_d   = ~win_last;
            lock_idx_d = win_idx;
          end
        end
      end
      S_STROBE: state_d = S_SETTLE;
      // The core's TXRDY has not dropped yet here, so it is not looked at.
      S_SETTLE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.txrdy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A lock whose owner has gone quiet is released after LOCK_TIMEOUT usable slots.
    if (LOCK_TIMEOUT > 0 && locked_q && !accept) begin
      if (bus.req_valid[lock_idx_q]) begin
        tcnt_d = '0;
      end else if (state_q == S_IDLE && bus.txrdy) begin
        if (tcnt_q == 16'(LOCK_TIMEOUT - 1)) begin
          locked_d = 1'b0;
          tcnt_d   = '0;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= 2'(NUM_REQ - 1);
      grant_q    <= '0;
      lock_idx_q <= '0;
      locked_q   <= 1'b0;
      data_q     <= '0;
      tcnt_q     <= '0;
      csn_q      <= 1'b1;
      wen_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      lock_idx_q <= lock_idx_d;
      locked_q   <= locked_d;
      data_q     <= data_d;
      tcnt_q     <= tcnt_d;
      csn_q      <= csn_d;
      wen_q      <= wen_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.uart_csn  = csn_q;
  assign bus.uart_wen  = wen_q;
  assign bus.uart_data = data_q;
  assign bus.grant     = grant_q;
  assign bus.locked    = locked_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - bench for uart_tx_arbiter against a transaction-level model
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam bit LE = 1'b1;
  localparam int LT = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();
  uart_tx_arbiter #(.NUM_REQ(N), .LOCK_EN(LE), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [8:0] src_q [N][$];
  int         core_cnt, core_len, gate_pct;
  bit         hold_low;

  bit         m_idle, m_locked;
  int         m_age, m_tcnt;
  logic [7:0] m_data;
  logic [1:0] m_grant, m_ptr, m_lock_idx;

  int         acc_n, strobe_cnt;
  int         acc_grant[$], acc_time[$];
  logic [7:0] acc_data[$];
  logic [N-1:0] last_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int r, input bit last, input logic [7:0] d);
    src_q[r].push_back({last, d});
  endtask

  task automatic model_reset();
    m_idle = 1'b1; m_age = 0; m_data = '0; m_grant = '0; m_ptr = 2'(N - 1);
    m_locked = 1'b0; m_lock_idx = '0; m_tcnt = 0; core_cnt = 0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    acc_grant.delete(); acc_data.delete(); acc_time.delete();
    acc_n = 0; strobe_cnt = 0;
  endtask

  function automatic int pick(input logic [N-1:0] v);
    if (m_locked) return v[m_lock_idx] ? int'(m_lock_idx) : -1;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (int'(m_ptr) + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_csn", 32'(bus.uart_csn), 32'd1);
    chk("rst_wen", 32'(bus.uart_wen), 32'd1);
    chk("rst_data", 32'(bus.uart_data), 32'd0);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_locked", 32'(bus.locked), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic cycle();
    logic [N-1:0] v;
    logic [N-1:0] exp_rdy;
    logic         txr;
    int           w;
    bit           acc, strobe_now;
    for (int i = 0; i < N; i++) begin
      v[i] = (src_q[i].size() > 0) && ($urandom_range(99) < gate_pct);
      bus.req_data[i*8 +: 8] = (src_q[i].size() > 0) ? src_q[i][0][7:0] : 8'($urandom);
      bus.req_last[i] = (src_q[i].size() > 0) ? src_q[i][0][8] : 1'($urandom);
    end
    txr = (core_cnt == 0) && !hold_low;
    bus.req_valid = v;
    bus.txrdy = txr;
    #1;
    w = pick(v);
    exp_rdy = (m_idle && txr && w >= 0) ? (4'(1) << w) : '0;
    strobe_now = !m_idle && (m_age == 0);
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("uart_csn", 32'(bus.uart_csn), 32'(!strobe_now));
    chk("uart_wen", 32'(bus.uart_wen), 32'(!strobe_now));
    chk("uart_data", 32'(bus.uart_data), 32'(m_data));
    chk("grant", 32'(bus.grant), 32'(m_grant));
    chk("locked", 32'(bus.locked), 32'(m_locked));
    chk("busy", 32'(bus.busy), 32'(!m_idle));
    last_rdy = bus.req_ready;
    if (bus.uart_csn === 1'b0) strobe_cnt++;
    acc = (exp_rdy != '0);
    @(posedge clk);
    // Core model: TXRDY drops for core_len cycles right after a strobe.
    if (strobe_now) core_cnt = core_len;
    else if (core_cnt > 0) core_cnt--;
    if (acc) begin
      m_idle = 1'b0; m_age = 0;
      m_data = src_q[w][0][7:0];
      m_grant = 2'(w); m_ptr = 2'(w);
      if (LE) begin
        m_locked = !src_q[w][0][8];
        m_lock_idx = 2'(w);
      end
      m_tcnt = 0;
      acc_grant.push_back(w); acc_data.push_back(m_data); acc_time.push_back(cyc);
      acc_n++;
      void'(src_q[w].pop_front());
    end else begin
      if (LT > 0 && m_locked) begin
        if (v[m_lock_idx]) m_tcnt = 0;
        else if (m_idle && txr) begin
          m_tcnt++;
          if (m_tcnt == LT) begin
            m_locked = 1'b0;
            m_tcnt = 0;
          end
        end
      end
      if (!m_idle) begin
        if (m_age >= 2 && txr) m_idle = 1'b1;
        m_age++;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (acc_n < target && n < budget) begin
      cycle();
      n++;
    end
    chk(tag, 32'(acc_n), 32'(target));
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.txrdy = 1'b1;
    core_len = 5; hold_low = 1'b0; gate_pct = 100;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single byte from requester 2.
    push(2, 1'b1, 8'h41);
    cycle();
    chk("s1_ready", 32'(last_rdy), 32'b0100);
    run_until(1, 5, "s1_accept");
    chk("s1_grant", 32'(acc_grant[0]), 32'd2);
    chk("s1_data", 32'(acc_data[0]), 32'h41);
    run_cycles(12);
    chk("s1_strobe_cycles", 32'(strobe_cnt), 32'd1);

    // All four continuously valid, every byte a complete packet.
    do_reset();
    for (int r = 0; r < N; r++) for (int b = 0; b < 3; b++) push(r, 1'b1, 8'($urandom));
    run_until(6, 80, "s2_accepts");
    for (int i = 0; i < 6; i++) chk("s2_grant", 32'(acc_grant[i]), 32'(i % 4));
    for (int i = 1; i < 6; i++) chk("s2_spacing", 32'(acc_time[i] - acc_time[i-1]), 32'd8);

    // Packet lock on requester 1 while 0 and 2 wait.
    do_reset();
    for (int b = 0; b < 6; b++) push(0, 1'b1, 8'h00 + 8'(b));
    push(1, 1'b0, 8'h10); push(1, 1'b0, 8'h11); push(1, 1'b1, 8'h12);
    push(2, 1'b1, 8'h20);
    run_until(5, 80, "s3_accepts");
    chk("s3_g0", 32'(acc_grant[0]), 32'd0);
    for (int i = 1; i < 4; i++) begin
      chk("s3_lock_grant", 32'(acc_grant[i]), 32'd1);
      chk("s3_lock_data", 32'(acc_data[i]), 32'h10 + 32'(i - 1));
    end
    chk("s3_after_lock", 32'(acc_grant[4]), 32'd2);

    // Stalled lock on requester 3 released by timeout.
    do_reset();
    push(3, 1'b0, 8'h33);
    run_until(1, 10, "s4_first");
    for (int b = 0; b < 2; b++) push(0, 1'b1, 8'h50 + 8'(b));
    run_until(2, 60, "s4_second");
    chk("s4_grant", 32'(acc_grant[1]), 32'd0);
    chk("s4_gap", 32'(acc_time[1] - acc_time[0]), 32'd16);

    // TXRDY held low blocks everything; release accepts at once.
    do_reset();
    for (int r = 0; r < N; r++) push(r, 1'b1, 8'h60 + 8'(r));
    hold_low = 1'b1;
    run_cycles(10);
    chk("s5_no_accept", 32'(acc_n), 32'd0);
    chk("s5_no_strobe", 32'(strobe_cnt), 32'd0);
    hold_low = 1'b0;
    cycle();
    chk("s5_accept_now", 32'(acc_n), 32'd1);
    run_cycles(10);

    // Reset during SETTLE while locked.
    do_reset();
    push(2, 1'b0, 8'h22);
    run_until(1, 10, "s6_lock_accept");
    cycle();
    chk("s6_in_settle", 32'(m_age), 32'd1);
    bus.req_valid = '1;
    bus.txrdy = 1'b1;
    do_reset();
    for (int r = 0; r < N; r++) push(r, 1'b1, 8'h70 + 8'(r));
    run_until(1, 5, "s6_after_reset");
    chk("s6_grant", 32'(acc_grant[0]), 32'd0);
    run_cycles(2);
    chk("s6_unlocked", 32'(bus.locked), 32'd0);

    // Randomised traffic, valid dropouts, lock/timeout mixes and a mid-run reset.
    do_reset();
    gate_pct = 75;
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      for (int r = 0; r < N; r++) begin
        if (src_q[r].size() < 3 && $urandom_range(3) == 0) push(r, 1'($urandom_range(1)), 8'($urandom));
      end
      core_len = $urandom_range(6);
      hold_low = ($urandom_range(9) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
